// File: rtl/trace_uart_tx.sv
// Commit-trace transmitter: buffers one record per retired instruction and streams
// each record as a fixed 14-byte 8N1 UART frame (sync, pc, instr, flags, wdata).
module trace_uart_tx #(
    parameter int          CLKS_PER_BIT = 234,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] HALT_PC      = 32'h80000080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        rec_valid,
    input  logic [31:0] rec_pc,
    input  logic [31:0] rec_instr,
    input  logic        rec_rf_wen,
    input  logic [4:0]  rec_rf_wsel,
    input  logic [31:0] rec_rf_wdata,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic [7:0]  dropped_cnt
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CNTW      = AW + 1;
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);
    localparam logic [3:0]      LAST_BYTE = 4'd13;
    localparam logic [7:0]      SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [31:0]     memPc    [FIFO_DEPTH];
    logic [31:0]     memInstr [FIFO_DEPTH];
    logic            memWen   [FIFO_DEPTH];
    logic [4:0]      memWsel  [FIFO_DEPTH];
    logic [31:0]     memData  [FIFO_DEPTH];

    logic [AW-1:0]   wrPtr_q, rdPtr_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            dropPending_q, dropPending_d;
    logic            halted_q;
    logic [7:0]      droppedCnt_q;

    state_t          state_q;
    logic [CW-1:0]   bitCnt_q;
    logic [2:0]      bitIdx_q;
    logic [3:0]      byteIdx_q;
    logic            txLine_q;
    logic            done_q;

    logic [31:0]     framePc_q;
    logic [31:0]     frameInstr_q;
    logic [7:0]      frameFlags_q;
    logic [31:0]     frameData_q;

    logic            bitLast;
    logic            frameEnd;
    logic            pop;
    logic            recFire;
    logic            push;
    logic            drop;
    logic [7:0]      curByte;

    // A pop happens either when idle or exactly as the last stop bit of a frame
    // ends, so back-to-back frames leave no gap on the line.
    assign bitLast  = (bitCnt_q == BIT_LAST);
    assign frameEnd = (state_q == S_STOP) && bitLast && (byteIdx_q == LAST_BYTE);
    assign pop      = !empty_q && ((state_q == S_IDLE) || frameEnd);
    assign recFire  = rec_valid && enable && !halted_q;
    assign push     = recFire && (!full_q || pop);
    assign drop     = recFire && full_q && !pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        // A drop coinciding with a pop must survive into the following frame.
        dropPending_d = drop || (dropPending_q && !pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memPc[wrPtr_q]    <= rec_pc;
            memInstr[wrPtr_q] <= rec_instr;
            memWen[wrPtr_q]   <= rec_rf_wen;
            memWsel[wrPtr_q]  <= rec_rf_wsel;
            memData[wrPtr_q]  <= rec_rf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            dropPending_q <= 1'b0;
            halted_q      <= 1'b0;
            droppedCnt_q  <= 8'd0;
        end else begin
            count_q       <= count_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            dropPending_q <= dropPending_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (push && (rec_pc == HALT_PC)) begin
                halted_q <= 1'b1;
            end
            if (drop && (droppedCnt_q != 8'hFF)) begin
                droppedCnt_q <= droppedCnt_q + 8'd1;
            end
        end
    end

    // Snapshot of the record being shifted; writeback data is zeroed when no write occurred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            framePc_q    <= '0;
            frameInstr_q <= '0;
            frameFlags_q <= '0;
            frameData_q  <= '0;
        end else if (pop) begin
            framePc_q    <= memPc[rdPtr_q];
            frameInstr_q <= memInstr[rdPtr_q];
            frameFlags_q <= {memWen[rdPtr_q], dropPending_q, 1'b0, memWsel[rdPtr_q]};
            frameData_q  <= memWen[rdPtr_q] ? memData[rdPtr_q] : 32'd0;
        end
    end

    always_comb begin
        curByte = SYNC_BYTE;
        case (byteIdx_q)
            4'd1:    curByte = framePc_q[7:0];
            4'd2:    curByte = framePc_q[15:8];
            4'd3:    curByte = framePc_q[23:16];
            4'd4:    curByte = framePc_q[31:24];
            4'd5:    curByte = frameInstr_q[7:0];
            4'd6:    curByte = frameInstr_q[15:8];
            4'd7:    curByte = frameInstr_q[23:16];
            4'd8:    curByte = frameInstr_q[31:24];
            4'd9:    curByte = frameFlags_q;
            4'd10:   curByte = frameData_q[7:0];
            4'd11:   curByte = frameData_q[15:8];
            4'd12:   curByte = frameData_q[23:16];
            4'd13:   curByte = frameData_q[31:24];
            default: curByte = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bitCnt_q  <= '0;
            bitIdx_q  <= 3'd0;
            byteIdx_q <= 4'd0;
            txLine_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q   <= S_START;
                        bitCnt_q  <= '0;
                        byteIdx_q <= 4'd0;
                        txLine_q  <= 1'b0;
                    end
                end
                S_START: begin
                    if (bitLast) begin
                        state_q  <= S_DATA;
                        bitCnt_q <= '0;
                        bitIdx_q <= 3'd0;
                        txLine_q <= curByte[0];
                    end else begin
                        bitCnt_q <= bitCnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bitLast) begin
                        bitCnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            state_q  <= S_STOP;
                            txLine_q <= 1'b1;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                            txLine_q <= curByte[bitIdx_q + 3'd1];
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bitLast) begin
                        bitCnt_q <= '0;
                        if (byteIdx_q != LAST_BYTE) begin
                            byteIdx_q <= byteIdx_q + 4'd1;
                            state_q   <= S_START;
                            txLine_q  <= 1'b0;
                        end else begin
                            if (framePc_q == HALT_PC) begin
                                done_q <= 1'b1;
                            end
                            if (pop) begin
                                byteIdx_q <= 4'd0;
                                state_q   <= S_START;
                                txLine_q  <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end else begin
                        bitCnt_q <= bitCnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    txLine_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx          = txLine_q;
    assign busy        = (state_q != S_IDLE) || !empty_q;
    assign done        = done_q;
    assign dropped_cnt = droppedCnt_q;

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed testbench for trace_uart_tx: a line monitor decodes UART bytes and each
// scenario task compares decoded frames, timing and status outputs against hand values.
module tb_trace_uart_tx;

    localparam int C     = 4;
    localparam int FRAME = 140 * C;

    typedef logic [111:0] frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        recValid = 1'b0;
    logic [31:0] recPc = '0;
    logic [31:0] recInstr = '0;
    logic        recWen = 1'b0;
    logic [4:0]  recWsel = '0;
    logic [31:0] recWdata = '0;
    logic        tx;
    logic        busy;
    logic        done;
    logic [7:0]  droppedCnt;

    int vecCount = 0;
    int missCount = 0;
    int cyc = 0;

    logic [7:0] rxq[$];
    int         rxStart[$];
    int         framingErrors = 0;

    trace_uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH(4),
        .HALT_PC(32'h80000080)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .rec_valid(recValid),
        .rec_pc(recPc),
        .rec_instr(recInstr),
        .rec_rf_wen(recWen),
        .rec_rf_wsel(recWsel),
        .rec_rf_wdata(recWdata),
        .tx(tx),
        .busy(busy),
        .done(done),
        .dropped_cnt(droppedCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line monitor: samples mid-bit on falling clock edges; bytes interrupted by reset are discarded.
    initial begin : monitor
        logic [7:0] b;
        logic       stopBit;
        bit         ok;
        int         s;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                s  = cyc;
                ok = 1'b1;
                b  = 8'h00;
                repeat (C / 2) @(negedge clk);
                if (!rst_n || tx !== 1'b0) ok = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    repeat (C) @(negedge clk);
                    b[k] = tx;
                    if (!rst_n) ok = 1'b0;
                end
                repeat (C) @(negedge clk);
                stopBit = tx;
                if (!rst_n) ok = 1'b0;
                if (ok) begin
                    if (stopBit !== 1'b1) framingErrors++;
                    rxq.push_back(b);
                    rxStart.push_back(s);
                end
            end
        end
    end

    function automatic frame_t buildFrame(input logic [31:0] pc, input logic [31:0] instr,
                                          input logic wen, input logic dp,
                                          input logic [4:0] wsel, input logic [31:0] wdata);
        logic [31:0] wd;
        wd = wen ? wdata : 32'd0;
        return {8'hA5, pc[7:0], pc[15:8], pc[23:16], pc[31:24],
                instr[7:0], instr[15:8], instr[23:16], instr[31:24],
                {wen, dp, 1'b0, wsel}, wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
    endfunction

    function automatic logic [7:0] frameByte(input frame_t f, input int k);
        return f[111 - 8 * k -: 8];
    endfunction

    task automatic sendRec(input logic [31:0] pc, input logic [31:0] instr, input logic wen,
                           input logic [4:0] wsel, input logic [31:0] wdata);
        recPc    = pc;
        recInstr = instr;
        recWen   = wen;
        recWsel  = wsel;
        recWdata = wdata;
        recValid = 1'b1;
        @(negedge clk);
        recValid = 1'b0;
    endtask

    task automatic waitBytes(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while (rxq.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (rxq.size() >= n);
    endtask

    task automatic waitIdle(input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vecCount++; if (tx !== 1'b1) begin missCount++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vecCount++; if (done !== 1'b0) begin missCount++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        vecCount++; if (droppedCnt !== 8'd0) begin missCount++; $display("[TB] FAIL reset_dropped: got %0d expected 0", droppedCnt); end
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        frame_t     expF;
        bit         ok;
        int         tN;
        int         s0;
        logic [7:0] got;
        expF = 112'hA5_00_00_00_80_93_00_50_00_81_05_00_00_00;
        rxq.delete(); rxStart.delete();
        sendRec(32'h80000000, 32'h00500093, 1'b1, 5'd1, 32'd5);
        tN = cyc;
        vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        waitBytes(14, FRAME + 100, ok);
        vecCount++;
        if (!ok) begin
            missCount++; $display("[TB] FAIL single_timeout: got %0d bytes expected 14", rxq.size());
        end else begin
            s0 = rxStart[0];
            vecCount++; if (s0 != tN + 1) begin missCount++; $display("[TB] FAIL single_latency: got start %0d expected %0d", s0, tN + 1); end
            vecCount++; if (rxStart[13] - s0 != 13 * 10 * C) begin missCount++; $display("[TB] FAIL single_spacing: got %0d expected %0d", rxStart[13] - s0, 13 * 10 * C); end
            for (int k = 0; k < 14; k++) begin
                got = rxq.pop_front();
                void'(rxStart.pop_front());
                vecCount++;
                if (got !== frameByte(expF, k)) begin missCount++; $display("[TB] FAIL single_byte%0d: got %h expected %h", k, got, frameByte(expF, k)); end
            end
            waitIdle(100);
            vecCount++; if (cyc != tN + 1 + FRAME) begin missCount++; $display("[TB] FAIL single_length: busy fell at %0d expected %0d", cyc, tN + 1 + FRAME); end
        end
        vecCount++; if (done !== 1'b0) begin missCount++; $display("[TB] FAIL single_done: got %b expected 0", done); end
    endtask

    task automatic test_no_writeback();
        frame_t     expF;
        bit         ok;
        logic [7:0] got;
        expF = 112'hA5_00_10_00_00_78_56_34_12_03_00_00_00_00;
        rxq.delete(); rxStart.delete();
        sendRec(32'h00001000, 32'h12345678, 1'b0, 5'd3, 32'hDEADBEEF);
        waitBytes(14, FRAME + 100, ok);
        vecCount++;
        if (!ok) begin
            missCount++; $display("[TB] FAIL nowb_timeout: got %0d bytes expected 14", rxq.size());
        end else begin
            for (int k = 0; k < 14; k++) begin
                got = rxq.pop_front();
                void'(rxStart.pop_front());
                vecCount++;
                if (got !== frameByte(expF, k)) begin missCount++; $display("[TB] FAIL nowb_byte%0d: got %h expected %h", k, got, frameByte(expF, k)); end
            end
        end
        waitIdle(100);
    endtask

    task automatic test_overflow();
        frame_t     expF;
        bit         ok;
        int         tN;
        int         s;
        logic [7:0] got;
        tN = 0;
        rxq.delete(); rxStart.delete();
        for (int i = 0; i < 7; i++) begin
            sendRec(32'h100 + 32'(4 * i), 32'h00100013 + 32'(i), ~i[0], 5'(i + 1), 32'hCAFE0000 | 32'(i));
            if (i == 0) tN = cyc;
        end
        vecCount++; if (droppedCnt !== 8'd2) begin missCount++; $display("[TB] FAIL ovf_dropped: got %0d expected 2", droppedCnt); end
        waitBytes(70, 5 * FRAME + 200, ok);
        vecCount++;
        if (!ok) begin
            missCount++; $display("[TB] FAIL ovf_timeout: got %0d bytes expected 70", rxq.size());
        end else begin
            for (int f = 0; f < 5; f++) begin
                expF = buildFrame(32'h100 + 32'(4 * f), 32'h00100013 + 32'(f), ~f[0], (f == 1),
                                  5'(f + 1), 32'hCAFE0000 | 32'(f));
                s = rxStart[0];
                vecCount++;
                if (s != tN + 1 + f * FRAME) begin missCount++; $display("[TB] FAIL ovf_start%0d: got %0d expected %0d", f, s, tN + 1 + f * FRAME); end
                for (int k = 0; k < 14; k++) begin
                    got = rxq.pop_front();
                    void'(rxStart.pop_front());
                    vecCount++;
                    if (got !== frameByte(expF, k)) begin missCount++; $display("[TB] FAIL ovf_f%0d_byte%0d: got %h expected %h", f, k, got, frameByte(expF, k)); end
                end
            end
        end
        repeat (200) @(negedge clk);
        vecCount++; if (rxq.size() != 0) begin missCount++; $display("[TB] FAIL ovf_extra: got %0d bytes expected 0", rxq.size()); end
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL ovf_busy: got %b expected 0", busy); end
    endtask

    task automatic test_halt();
        frame_t     expF;
        bit         ok;
        int         s2;
        int         t;
        logic [7:0] got;
        rxq.delete(); rxStart.delete();
        sendRec(32'h8000007C, 32'h00000013, 1'b1, 5'd2, 32'd7);
        sendRec(32'h80000080, 32'h0000006F, 1'b0, 5'd0, 32'h55);
        sendRec(32'h80000084, 32'h00000093, 1'b1, 5'd4, 32'd9);
        vecCount++; if (done !== 1'b0) begin missCount++; $display("[TB] FAIL halt_done_early: got %b expected 0", done); end
        waitBytes(28, 2 * FRAME + 100, ok);
        vecCount++;
        if (!ok) begin
            missCount++; $display("[TB] FAIL halt_timeout: got %0d bytes expected 28", rxq.size());
        end else begin
            s2 = rxStart[14];
            for (int f = 0; f < 2; f++) begin
                if (f == 0) expF = buildFrame(32'h8000007C, 32'h00000013, 1'b1, 1'b0, 5'd2, 32'd7);
                else        expF = buildFrame(32'h80000080, 32'h0000006F, 1'b0, 1'b0, 5'd0, 32'h55);
                for (int k = 0; k < 14; k++) begin
                    got = rxq.pop_front();
                    void'(rxStart.pop_front());
                    vecCount++;
                    if (got !== frameByte(expF, k)) begin missCount++; $display("[TB] FAIL halt_f%0d_byte%0d: got %h expected %h", f, k, got, frameByte(expF, k)); end
                end
            end
            t = 0;
            while (!done && t < 200) begin
                @(negedge clk);
                t++;
            end
            vecCount++; if (cyc != s2 + FRAME) begin missCount++; $display("[TB] FAIL halt_done_time: got %0d expected %0d", cyc, s2 + FRAME); end
        end
        sendRec(32'h00000200, 32'h00000013, 1'b1, 5'd1, 32'd1);
        repeat (FRAME + 100) @(negedge clk);
        vecCount++; if (rxq.size() != 0) begin missCount++; $display("[TB] FAIL halt_extra: got %0d bytes expected 0", rxq.size()); end
        vecCount++; if (droppedCnt !== 8'd2) begin missCount++; $display("[TB] FAIL halt_dropped: got %0d expected 2", droppedCnt); end
        vecCount++; if (done !== 1'b1) begin missCount++; $display("[TB] FAIL halt_done_sticky: got %b expected 1", done); end
    endtask

    task automatic test_reset_midframe();
        frame_t     expF;
        bit         ok;
        logic [7:0] got;
        expF = 112'hA5_40_00_00_00_13_01_A0_00_82_0A_00_00_00;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        rxq.delete(); rxStart.delete();
        sendRec(32'h00000000, 32'hFFFFFFFF, 1'b1, 5'd7, 32'd1);
        repeat (170) @(negedge clk);
        vecCount++; if (tx !== 1'b0) begin missCount++; $display("[TB] FAIL mid_tx_before: got %b expected 0", tx); end
        #1 rst_n = 1'b0;
        #1;
        vecCount++; if (tx !== 1'b1) begin missCount++; $display("[TB] FAIL mid_tx_async: got %b expected 1", tx); end
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
        vecCount++; if (done !== 1'b0) begin missCount++; $display("[TB] FAIL mid_done: got %b expected 0", done); end
        vecCount++; if (droppedCnt !== 8'd0) begin missCount++; $display("[TB] FAIL mid_dropped: got %0d expected 0", droppedCnt); end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (60) @(negedge clk);
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL mid_busy_after: got %b expected 0", busy); end
        rxq.delete(); rxStart.delete();
        sendRec(32'h00000040, 32'h00A00113, 1'b1, 5'd2, 32'd10);
        waitBytes(14, FRAME + 100, ok);
        vecCount++;
        if (!ok) begin
            missCount++; $display("[TB] FAIL mid_timeout: got %0d bytes expected 14", rxq.size());
        end else begin
            for (int k = 0; k < 14; k++) begin
                got = rxq.pop_front();
                void'(rxStart.pop_front());
                vecCount++;
                if (got !== frameByte(expF, k)) begin missCount++; $display("[TB] FAIL mid_byte%0d: got %h expected %h", k, got, frameByte(expF, k)); end
            end
        end
        waitIdle(100);
    endtask

    task automatic test_enable_gating();
        rxq.delete(); rxStart.delete();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sendRec(32'h300 + 32'(4 * i), 32'h00000013, 1'b1, 5'd1, 32'(i));
        end
        repeat (100) @(negedge clk);
        vecCount++; if (rxq.size() != 0) begin missCount++; $display("[TB] FAIL gate_bytes: got %0d expected 0", rxq.size()); end
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL gate_busy: got %b expected 0", busy); end
        vecCount++; if (droppedCnt !== 8'd0) begin missCount++; $display("[TB] FAIL gate_dropped: got %0d expected 0", droppedCnt); end
        enable = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 305; i++) begin
            sendRec(32'h400 + 32'(4 * i), 32'h00000013, 1'b1, 5'd1, 32'(i));
        end
        vecCount++; if (droppedCnt !== 8'd255) begin missCount++; $display("[TB] FAIL sat_dropped: got %0d expected 255", droppedCnt); end
        vecCount++; if (busy !== 1'b1) begin missCount++; $display("[TB] FAIL sat_busy: got %b expected 1", busy); end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        vecCount++; if (droppedCnt !== 8'd0) begin missCount++; $display("[TB] FAIL sat_cleared: got %0d expected 0", droppedCnt); end
    endtask

    task automatic test_framing();
        vecCount++;
        if (framingErrors != 0) begin missCount++; $display("[TB] FAIL framing: got %0d stop-bit errors expected 0", framingErrors); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_no_writeback();
        test_overflow();
        test_halt();
        test_reset_midframe();
        test_enable_gating();
        test_saturation();
        test_framing();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
